ntt_lane_sequencer: RTL and testbench

- Parametrised successor of the closely-coupled NTT top-level.
- Autonomously runs a complete forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande) over an N = 2**ADDR_WIDTH coefficient register file.
- Issues NUM_BF butterflies per cycle to external fixed-latency butterfly lanes and writes the results back.
- Sits between the PQ register file and the butterfly/omega units. Removes per-butterfly core instructions.

---
 rtl/ntt_lane_sequencer.sv | 174 +++++++++++++++++
 tb/tb_ntt_lane_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_lane_sequencer.sv
// rtl/ntt_lane_sequencer.sv - NTT/INTT stage sequencer feeding NUM_BF butterfly lanes with delayed write-back.
// Optional cycle counter port perf_cycles_o is built when NTT_SEQ_PERF_CNT_EN is defined.
module ntt_lane_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BF     = 2,
  parameter int BF_LAT     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         fwd_ntt,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_BF*ADDR_WIDTH-1:0] raddr_a_o,
  output logic [NUM_BF*ADDR_WIDTH-1:0] raddr_b_o,
  input  logic [NUM_BF*DATA_WIDTH-1:0] rdata_a_i,
  input  logic [NUM_BF*DATA_WIDTH-1:0] rdata_b_i,
  output logic                         bf_valid_o,
  output logic [NUM_BF*DATA_WIDTH-1:0] bf_a_o,
  output logic [NUM_BF*DATA_WIDTH-1:0] bf_b_o,
  output logic [NUM_BF*ADDR_WIDTH-1:0] bf_tw_idx_o,
  input  logic [NUM_BF*DATA_WIDTH-1:0] bf_a_i,
  input  logic [NUM_BF*DATA_WIDTH-1:0] bf_b_i,
  output logic [NUM_BF*ADDR_WIDTH-1:0] waddr_a_o,
  output logic [NUM_BF*ADDR_WIDTH-1:0] waddr_b_o,
  output logic [NUM_BF*DATA_WIDTH-1:0] wdata_a_o,
  output logic [NUM_BF*DATA_WIDTH-1:0] wdata_b_o,
  output logic [NUM_BF-1:0]            we_o
`ifdef NTT_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_cycles_o
`endif
);

  localparam int AW   = ADDR_WIDTH;
  localparam int AW1  = ADDR_WIDTH + 1;
  localparam int N    = 1 << AW;
  localparam int HALF = N / 2;
  localparam int CW   = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nx;
  logic          fwd_q;
  logic [AW-1:0] stage;
  logic [AW-1:0] k;
  logic [CW-1:0] dcnt;
  logic          issue;
  logic          last_issue, last_drain, last_stage;

  assign last_issue = (k == AW'(HALF - NUM_BF));
  assign last_drain = (dcnt == CW'(BF_LAT - 1));
  assign last_stage = (stage == AW'(AW - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (last_issue) state_nx = S_DRAIN;
      S_DRAIN: if (last_drain) state_nx = last_stage ? S_DONE : S_ISSUE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == S_ISSUE) || (state == S_DRAIN);
    done  = (state == S_DONE);
    issue = (state == S_ISSUE);
  end

  assign bf_valid_o = issue;

  // The drain wait doubles as the RAW barrier: the next stage reads only after the last write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q <= 1'b0;
      stage <= '0;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          fwd_q <= fwd_ntt;
          stage <= '0;
          k     <= '0;
        end
        S_ISSUE: begin
          k    <= k + AW'(NUM_BF);
          dcnt <= '0;
        end
        S_DRAIN: begin
          dcnt <= dcnt + CW'(1);
          if (last_drain) begin
            k <= '0;
            if (!last_stage) stage <= stage + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  logic [AW-1:0] len_log, len_v, len_mask;
  logic [AW:0]   n_shift;

  assign len_log  = fwd_q ? (AW'(AW - 1) - stage) : stage;
  assign len_v    = AW'(1) << len_log;
  assign len_mask = len_v - AW'(1);
  assign n_shift  = AW1'(N) >> stage;

  logic [BF_LAT-1:0]          v_pipe;
  logic [NUM_BF*AW-1:0]       wa_pipe [BF_LAT];
  logic [NUM_BF*AW-1:0]       wb_pipe [BF_LAT];

  for (genvar i = 0; i < NUM_BF; i++) begin : g_lane
    logic [AW-1:0] kk, g, a, b, tw;
    assign kk = k + AW'(i);
    assign g  = kk >> len_log;
    // a = 2*g*len + pos: shift the group bits up one place and keep the in-group offset.
    assign a  = ((kk & ~len_mask) << 1) | (kk & len_mask);
    assign b  = a | len_v;
    assign tw = fwd_q ? ((AW'(1) << stage) + g) : AW'(n_shift - AW1'(1) - {1'b0, g});

    assign raddr_a_o[i*AW +: AW]   = issue ? a : '0;
    assign raddr_b_o[i*AW +: AW]   = issue ? b : '0;
    assign bf_tw_idx_o[i*AW +: AW] = issue ? tw : '0;
    assign we_o[i] = v_pipe[BF_LAT-1] &&
                     (wa_pipe[BF_LAT-1][i*AW +: AW] != wb_pipe[BF_LAT-1][i*AW +: AW]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      for (int j = 0; j < BF_LAT; j++) begin
        wa_pipe[j] <= '0;
        wb_pipe[j] <= '0;
      end
    end else begin
      v_pipe[0]  <= issue;
      wa_pipe[0] <= raddr_a_o;
      wb_pipe[0] <= raddr_b_o;
      for (int j = 1; j < BF_LAT; j++) begin
        v_pipe[j]  <= v_pipe[j-1];
        wa_pipe[j] <= wa_pipe[j-1];
        wb_pipe[j] <= wb_pipe[j-1];
      end
    end
  end

  assign bf_a_o    = rdata_a_i;
  assign bf_b_o    = rdata_b_i;
  assign waddr_a_o = wa_pipe[BF_LAT-1];
  assign waddr_b_o = wb_pipe[BF_LAT-1];
  assign wdata_a_o = bf_a_i;
  assign wdata_b_o = bf_b_i;

`ifdef NTT_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (rst)                               perf_q <= '0;
    else if (state == S_IDLE && start)     perf_q <= '0;
    else if (state != S_IDLE && perf_q != '1) perf_q <= perf_q + 32'd1;
  end
  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_ntt_lane_sequencer.sv
// tb/tb_ntt_lane_sequencer.sv - scoreboard bench for ntt_lane_sequencer (N=8, two lanes, latency 2).
module tb_ntt_lane_sequencer;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int NB = 2;
  localparam int LAT = 2;
  localparam int N = 8;
  localparam longint Q = 3329;

  logic clk = 1'b0;
  logic rst, start, fwd_ntt;
  logic busy, done, bf_valid;
  logic [NB*AW-1:0] raddr_a, raddr_b, tw_idx, waddr_a, waddr_b;
  logic [NB*DW-1:0] rdata_a, rdata_b, bf_a, bf_b, res_a, res_b, wdata_a, wdata_b;
  logic [NB-1:0] we;
`ifdef NTT_SEQ_PERF_CNT_EN
  logic [31:0] perf;
`endif

  always #5 clk = ~clk;

  ntt_lane_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BF(NB), .BF_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .fwd_ntt(fwd_ntt), .busy(busy), .done(done),
    .raddr_a_o(raddr_a), .raddr_b_o(raddr_b), .rdata_a_i(rdata_a), .rdata_b_i(rdata_b),
    .bf_valid_o(bf_valid), .bf_a_o(bf_a), .bf_b_o(bf_b), .bf_tw_idx_o(tw_idx),
    .bf_a_i(res_a), .bf_b_i(res_b), .waddr_a_o(waddr_a), .waddr_b_o(waddr_b),
    .wdata_a_o(wdata_a), .wdata_b_o(wdata_b), .we_o(we)
`ifdef NTT_SEQ_PERF_CNT_EN
    , .perf_cycles_o(perf)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  longint tw_tab [N];
  logic [DW-1:0] mem [N];
  logic [DW-1:0] img [N];
  logic load = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else begin
      for (int i = 0; i < NB; i++)
        if (we[i]) begin
          mem[waddr_a[i*AW +: AW]] <= wdata_a[i*DW +: DW];
          mem[waddr_b[i*AW +: AW]] <= wdata_b[i*DW +: DW];
        end
    end
  end

  function automatic logic [2*DW-1:0] bfly(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                           input logic [AW-1:0] t);
    longint u, v;
    if (mode == 0) return {x + 32'd1, y + 32'd2};
    u = longint'(x);
    v = longint'(y);
    return {DW'((u + v) % Q), DW'((((u - v + Q) % Q) * tw_tab[t]) % Q)};
  endfunction

  logic [DW-1:0] pa [LAT][NB];
  logic [DW-1:0] pb [LAT][NB];
  logic [2*DW-1:0] lane_r;
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      lane_r = bfly(bf_a[i*DW +: DW], bf_b[i*DW +: DW], tw_idx[i*AW +: AW]);
      pa[0][i] <= lane_r[2*DW-1:DW];
      pb[0][i] <= lane_r[DW-1:0];
      for (int j = 1; j < LAT; j++) begin
        pa[j][i] <= pa[j-1][i];
        pb[j][i] <= pb[j-1][i];
      end
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_env
    assign rdata_a[i*DW +: DW] = mem[raddr_a[i*AW +: AW]];
    assign rdata_b[i*DW +: DW] = mem[raddr_b[i*AW +: AW]];
    assign res_a[i*DW +: DW]   = pa[LAT-1][i];
    assign res_b[i*DW +: DW]   = pb[LAT-1][i];
  end

  typedef struct { logic [AW-1:0] a; logic [AW-1:0] b; logic [AW-1:0] tw; } iss_t;
  typedef struct { logic [AW-1:0] a; logic [AW-1:0] b; logic [DW-1:0] da; logic [DW-1:0] db; int cyc; } wr_t;
  iss_t iss_q [$];
  wr_t  wr_q [$];
  logic [3*AW-1:0] fwd_tab [12];
  logic [3*AW-1:0] inv_tab [12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic push_run(input bit f);
    logic [3*AW-1:0] e;
    iss_t it;
    for (int i = 0; i < 12; i++) begin
      e = f ? fwd_tab[i] : inv_tab[i];
      it.a = e[8:6];
      it.b = e[5:3];
      it.tw = e[2:0];
      iss_q.push_back(it);
    end
  endtask

  // Issue side pops the hand table and predicts the write; write side pops and compares.
  iss_t mi;
  wr_t  mw;
  logic [2*DW-1:0] mr;
  always @(negedge clk) begin
    if (bf_valid) begin
      for (int i = 0; i < NB; i++) begin
        if (iss_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL issue_unexpected lane=%0d a=%0d b=%0d", i, raddr_a[i*AW +: AW], raddr_b[i*AW +: AW]);
        end else begin
          mi = iss_q.pop_front();
          chk("issue_a_b_tw", {raddr_a[i*AW +: AW], raddr_b[i*AW +: AW], tw_idx[i*AW +: AW]},
              {mi.a, mi.b, mi.tw});
          mr = bfly(mem[mi.a], mem[mi.b], mi.tw);
          mw.a = mi.a;
          mw.b = mi.b;
          mw.da = mr[2*DW-1:DW];
          mw.db = mr[DW-1:0];
          mw.cyc = cyc + LAT;
          wr_q.push_back(mw);
        end
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (we[i]) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL write_unexpected lane=%0d a=%0d b=%0d", i, waddr_a[i*AW +: AW], waddr_b[i*AW +: AW]);
        end else begin
          mw = wr_q.pop_front();
          chk("wb_addr", {waddr_a[i*AW +: AW], waddr_b[i*AW +: AW]}, {mw.a, mw.b});
          chk("wb_data", {wdata_a[i*DW +: DW], wdata_b[i*DW +: DW]}, {mw.da, mw.db});
          chk("wb_timing", 64'(cyc), 64'(mw.cyc));
        end
      end
    end
  end

  task automatic load_mem();
    load = 1'b1;
    @(posedge clk);
    #2 load = 1'b0;
  endtask

  task automatic go(input bit f);
    start = 1'b1;
    fwd_ntt = f;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end while (!done && lat < 200);
  endtask

  task automatic check_inc(input string nm, input int times);
    for (int x = 0; x < N; x++)
      chk(nm, 64'(mem[x]), 64'(img[x] + DW'(times * (3 + $countones(x)))));
  endtask

  longint ref_r [N];
  task automatic ref_intt();
    longint u, v, w;
    int len;
    for (int i = 0; i < N; i++) ref_r[i] = longint'(img[i]);
    for (int s = 0; s < AW; s++) begin
      len = 1 << s;
      for (int st = 0; st < N; st += 2 * len)
        for (int j = st; j < st + len; j++) begin
          u = ref_r[j];
          v = ref_r[j + len];
          w = tw_tab[N / len - 1 - st / (2 * len)];
          ref_r[j] = (u + v) % Q;
          ref_r[j + len] = (((u - v + Q) % Q) * w) % Q;
        end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, bc;
    logic any;
    rst = 1'b1;
    start = 1'b0;
    fwd_ntt = 1'b0;
    tw_tab[0] = 1;
    for (int i = 1; i < N; i++) tw_tab[i] = (tw_tab[i-1] * 17) % Q;
    fwd_tab = '{{3'd0,3'd4,3'd1}, {3'd1,3'd5,3'd1}, {3'd2,3'd6,3'd1}, {3'd3,3'd7,3'd1},
                {3'd0,3'd2,3'd2}, {3'd1,3'd3,3'd2}, {3'd4,3'd6,3'd3}, {3'd5,3'd7,3'd3},
                {3'd0,3'd1,3'd4}, {3'd2,3'd3,3'd5}, {3'd4,3'd5,3'd6}, {3'd6,3'd7,3'd7}};
    inv_tab = '{{3'd0,3'd1,3'd7}, {3'd2,3'd3,3'd6}, {3'd4,3'd5,3'd5}, {3'd6,3'd7,3'd4},
                {3'd0,3'd2,3'd3}, {3'd1,3'd3,3'd3}, {3'd4,3'd6,3'd2}, {3'd5,3'd7,3'd2},
                {3'd0,3'd4,3'd1}, {3'd1,3'd5,3'd1}, {3'd2,3'd6,3'd1}, {3'd3,3'd7,3'd1}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_valid", 64'(bf_valid), 0);
    chk("rst_we", 64'(we), 0);
    chk("rst_addr", {raddr_a, raddr_b, tw_idx, waddr_a, waddr_b}, 0);
`ifdef NTT_SEQ_PERF_CNT_EN
    chk("rst_perf", 64'(perf), 0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;

    // Forward run with the +1/+2 lane model.
    mode = 0;
    for (int i = 0; i < N; i++) img[i] = DW'(i * 16 + 3);
    load_mem();
    push_run(1'b1);
    go(1'b1);
    start = 1'b0;
    wait_done(lat, bc);
    chk("fwd_done_latency", 64'(lat), 13);
    chk("fwd_busy_cycles", 64'(bc), 12);
    chk("fwd_busy_at_done", 64'(busy), 0);
    check_inc("fwd_mem", 1);
    chk("fwd_queues_empty", 64'(iss_q.size() + wr_q.size()), 0);
    @(posedge clk);
    #2;
`ifdef NTT_SEQ_PERF_CNT_EN
    chk("perf_after_done", 64'(perf), 13);
    repeat (3) @(posedge clk);
    #2 chk("perf_holds", 64'(perf), 13);
`endif

    // Inverse run with a modular Gentleman-Sande butterfly.
    mode = 1;
    for (int i = 0; i < N; i++) img[i] = DW'((i * 419 + 11) % 3329);
    load_mem();
    ref_intt();
    push_run(1'b0);
    go(1'b0);
    start = 1'b0;
`ifdef NTT_SEQ_PERF_CNT_EN
    chk("perf_cleared_on_start", 64'(perf), 0);
`endif
    wait_done(lat, bc);
    chk("inv_done_latency", 64'(lat), 13);
    for (int x = 0; x < N; x++) chk("inv_mem_vs_model", 64'(mem[x]), 64'(ref_r[x]));

    // Start held high: the second transform begins only after the idle cycle following done.
    mode = 0;
    for (int i = 0; i < N; i++) img[i] = DW'(i * 7 + 100);
    @(posedge clk);
    #2;
    load_mem();
    push_run(1'b1);
    push_run(1'b1);
    go(1'b1);
    wait_done(lat, bc);
    chk("held_run1_latency", 64'(lat), 13);
    @(posedge clk);
    @(negedge clk);
    chk("held_idle_gap_busy", 64'(busy), 0);
    @(posedge clk);
    #2;
    start = 1'b0;
    fwd_ntt = 1'b0;
    wait_done(lat, bc);
    chk("held_run2_latency", 64'(lat), 13);
    chk("held_run2_busy_cycles", 64'(bc), 12);
    check_inc("held_mem", 2);

    // Reset during stage-1 issue, then a clean rerun.
    @(posedge clk);
    #2;
    load_mem();
    push_run(1'b1);
    go(1'b1);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_mid_in_issue", 64'(bf_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    iss_q.delete();
    wr_q.delete();
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 0);
    chk("rst_mid_we", 64'(we), 0);
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any = any | (|we) | busy;
    end
    chk("rst_mid_no_activity", 64'(any), 0);
    @(posedge clk);
    #2;
    load_mem();
    push_run(1'b1);
    go(1'b1);
    start = 1'b0;
    wait_done(lat, bc);
    chk("rerun_done_latency", 64'(lat), 13);
    check_inc("rerun_mem", 1);
    chk("final_queues_empty", 64'(iss_q.size() + wr_q.size()), 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
